cpu_fetch: RTL and testbench
============================

# cpu_fetch

- Instruction fetch stage; it sits directly upstream of the decode stage and produces its `fetch_data_t` input.
- Issues 32-bit word reads on the instruction bus and pre-extracts register indices.
- Tags each new instruction so downstream stages detect fresh data by tag change.
- Stops after any control-transfer instruction until execute returns the resolved next PC.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC of first fetch after reset.

Ports:
- i_clock  in  1  Single clock. All state changes on the rising edge.
- i_reset_n  in  1  Reset, asynchronous and active-low.
- o_fault  out  1  Sticky; set on a misaligned PC.
- o_bus_request  out  1  Instruction read request.
- i_bus_ready  in  1  Read data valid; completes the request.
- o_bus_address  out  32  Byte address of the word being read.
- i_bus_rdata  in  32  Instruction word.
- i_stall  in  1  Downstream cannot take a new instruction; `o_data` must hold.
- i_jump  in  1  Execute has resolved the pending control transfer.
- i_jump_tag  in  tag_t  Tag of the resolved control-transfer instruction.
- i_jump_pc  in  32  Resolved next PC (taken target or fall-through).
- o_data  out  fetch_data_t  Fields: pc, instruction, inst_rs1, inst_rs2, inst_rs3, inst_rd, tag.

## Operation
- Field extraction from a fetched word:
  - inst_rs1 = [19:15]
  - inst_rs2 = [24:20]
  - inst_rs3 = [31:27]
  - inst_rd = [11:7]
  - Fields are extracted unconditionally; decode qualifies them by format.
- Control-transfer instruction: opcode [6:0] is 1101111 (JAL), 1100111 (JALR) or 1100011 (branch).
- Registers:
  - pc
  - hold buffer (valid bit + 32-bit word + pc)
  - pending tag
  - `o_data`
- State FETCH:
  - o_bus_request = 1 while the hold buffer is empty. o_bus_address = pc.
  - On i_bus_ready:
    - If i_stall = 0, publish the word to `o_data`.
    - If i_stall = 1, store the word in the hold buffer and drop the request.
  - After publishing, the next state depends on the instruction:
    - Control transfer: record its tag as pending and go to WAIT_JUMP.
    - Otherwise: pc += 4 and stay in FETCH.
  - Hold buffer valid and i_stall = 0: publish the buffered word and clear the buffer. The buffer has priority over a new bus read.
- Publish means:
  - o_data.tag increments (tag_t, modulo 2^width, wraps to 0).
  - All other `o_data` fields update together.
- State WAIT_JUMP:
  - o_bus_request = 0.
  - On i_jump with i_jump_tag == pending tag: pc = i_jump_pc, go to FETCH.
  - A non-matching i_jump is ignored.
- State HALT:
  - Entered from FETCH when pc[1:0] != 0 (checked before the request is raised).
  - o_fault = 1, no requests.
  - Left only by reset.
- i_stall never alters `o_data`; `o_data` changes only on a publish.

## Timing
- Reset values:
  - o_fault = 0
  - o_bus_request = 0
  - o_bus_address = RESET_VECTOR
  - o_data = 0 (tag 0)
  - pc = RESET_VECTOR
  - state = FETCH
  - hold buffer empty
- First request is asserted in the first cycle after i_reset_n rises. It is registered, so there is no combinational path from reset.
- Latency: the edge sampling i_bus_ready = 1 (with i_stall = 0) updates `o_data`; it is visible the following cycle.
- Sequential throughput: one instruction per cycle with zero-wait bus.
  - o_bus_request stays high across back-to-back reads.
  - o_bus_address advances on the same edge that publishes.
- i_jump is sampled in the cycle it is high.
  - The first request at i_jump_pc is asserted the next cycle.
  - An i_jump in the same cycle the branch is published is not possible; the pending tag is not yet valid, so it is ignored.
- Stall arriving together with i_bus_ready: the word goes to the hold buffer, so no data is lost.
- Stall released: the buffered word is published on that edge and the bus request re-asserts the cycle after.
- Reset asserted mid-request: all state clears immediately, the request drops asynchronously, and any late i_bus_ready is ignored.
- Tag wraps from all-ones to 0 with no special handling.

## Structure
- The cpu package defines:
  - `fetch_data_t`
  - `tag_t`
  - the opcode constants (OP_JAL, OP_JALR, OP_BRANCH)
  - the field-slice positions
- Sub-module `cpu_fetch_buffer`: a one-entry hold buffer (valid/word/pc, load/unload). It is reusable by the load-store stage.
- The FSM (FETCH / WAIT_JUMP / HALT) lives in `cpu_fetch` as an enum.

## Test plan
1. **Reset and sequential fetch.** RESET_VECTOR = 0; bus ready every cycle, returning NOP 0x00000013 → addresses 0, 4, 8 on consecutive cycles; o_data.tag = 1, 2, 3; o_data.pc lags address by one cycle.
2. **Field extraction.** Word 0x00A58533 (add a0,a1,a0) → inst_rd = 10, inst_rs1 = 11, inst_rs2 = 10, inst_rs3 = 0.
3. **Branch wait.** Word 0xFE000EE3 at pc 0x10 → request low. i_jump with a wrong tag is ignored. i_jump tag = pending, pc 0x100 → next request address 0x100.
4. **Stall during ready.** i_stall = 1 in the i_bus_ready cycle → `o_data` unchanged and request drops. Release after 3 cycles → word published on release with tag +1; request resumes at pc + 4.
5. **Misalignment.** i_jump_pc = 0x102 → o_fault = 1 next cycle, no further requests; i_reset_n low clears o_fault.
6. **Tag wrap and async reset.** With tag at max, one more publish → tag = 0. Assert i_reset_n low mid-cycle → o_bus_request = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_fetch_pkg.sv
// rtl/cpu_fetch_pkg.sv - shared types, opcodes and field positions for the fetch stage
package cpu_fetch_pkg;

    localparam int TAG_W    = 4;
    localparam int REG_W    = 5;
    localparam int OPCODE_W = 7;

    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RS3_LSB = 27;
    localparam int RD_LSB  = 7;

    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
        reg_idx_t    inst_rs1;
        reg_idx_t    inst_rs2;
        reg_idx_t    inst_rs3;
        reg_idx_t    inst_rd;
        tag_t        tag;
    } fetch_data_t;

    function automatic logic is_control_transfer(input logic [31:0] word);
        logic [OPCODE_W-1:0] opcode;
        opcode = word[OPCODE_W-1:0];
        return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BRANCH);
    endfunction

    // Register indices are sliced regardless of format; decode decides which are meaningful.
    function automatic fetch_data_t extract_fields(input logic [31:0] word,
                                                   input logic [31:0] pc,
                                                   input tag_t        tag);
        fetch_data_t f;
        f.pc          = pc;
        f.instruction = word;
        f.inst_rs1    = word[RS1_LSB +: REG_W];
        f.inst_rs2    = word[RS2_LSB +: REG_W];
        f.inst_rs3    = word[RS3_LSB +: REG_W];
        f.inst_rd     = word[RD_LSB  +: REG_W];
        f.tag         = tag;
        return f;
    endfunction

endpackage

// File: rtl/cpu_fetch_buffer.sv
// rtl/cpu_fetch_buffer.sv - one-entry hold buffer (valid/word/pc) with load and unload
module cpu_fetch_buffer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load,
    input  logic        unload,
    input  logic [31:0] load_word,
    input  logic [31:0] load_pc,
    output logic        valid,
    output logic [31:0] word,
    output logic [31:0] pc
);

    // Load wins over unload so a simultaneous refill never loses the new entry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            word  <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= load_word;
            pc    <= load_pc;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// rtl/cpu_fetch.sv - instruction fetch stage feeding decode with tagged fetch records
module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    output logic        o_fault,
    output logic        o_bus_request,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_address,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_stall,
    input  logic        i_jump,
    input  tag_t        i_jump_tag,
    input  logic [31:0] i_jump_pc,
    output fetch_data_t o_data
);

    typedef enum logic [1:0] {FETCH, WAIT_JUMP, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic        req, req_next;
    logic        fault, fault_next;
    tag_t        pending, pending_next;
    tag_t        next_tag;
    fetch_data_t data, data_next;

    logic        buf_valid, buf_valid_next;
    logic [31:0] buf_word, buf_pc;

    logic        take_bus, from_buf, buf_load, publish, pub_ct, jump_hit;
    logic [31:0] pub_word, pub_pc;

    assign o_bus_request = req;
    assign o_bus_address = pc;
    assign o_fault       = fault;
    assign o_data        = data;

    // A buffered word always drains before the bus is used again.
    assign take_bus       = (state == FETCH) && req && i_bus_ready && !buf_valid;
    assign from_buf       = (state == FETCH) && buf_valid && !i_stall;
    assign buf_load       = take_bus && i_stall;
    assign publish        = from_buf || (take_bus && !i_stall);
    assign pub_word       = from_buf ? buf_word : i_bus_rdata;
    assign pub_pc         = from_buf ? buf_pc : pc;
    assign pub_ct         = is_control_transfer(pub_word);
    assign jump_hit       = (state == WAIT_JUMP) && i_jump && (i_jump_tag == pending);
    assign buf_valid_next = buf_load || (buf_valid && !from_buf);
    assign next_tag       = data.tag + tag_t'(1);

    cpu_fetch_buffer u_hold (
        .clock     (i_clock),
        .reset_n   (i_reset_n),
        .load      (buf_load),
        .unload    (from_buf),
        .load_word (i_bus_rdata),
        .load_pc   (pc),
        .valid     (buf_valid),
        .word      (buf_word),
        .pc        (buf_pc)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH: begin
                if (pc[1:0] != 2'b00) begin
                    state_next = HALT;
                end else if (publish && pub_ct) begin
                    state_next = WAIT_JUMP;
                end
            end
            WAIT_JUMP: begin
                if (jump_hit) begin
                    state_next = (i_jump_pc[1:0] != 2'b00) ? HALT : FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = HALT;
        endcase
    end

    // Request and fault are computed one edge ahead so both come straight from flops.
    always_comb begin
        pc_next      = pc;
        data_next    = data;
        pending_next = pending;
        if (publish) begin
            data_next = extract_fields(pub_word, pub_pc, next_tag);
            if (pub_ct) begin
                pending_next = next_tag;
            end else begin
                pc_next = pub_pc + 32'd4;
            end
        end
        if (jump_hit) begin
            pc_next = i_jump_pc;
        end
        req_next   = (state_next == FETCH) && !buf_valid_next && (pc_next[1:0] == 2'b00);
        fault_next = fault || (state_next == HALT);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pc      <= RESET_VECTOR;
            req     <= 1'b0;
            fault   <= 1'b0;
            pending <= '0;
            data    <= '0;
        end else begin
            pc      <= pc_next;
            req     <= req_next;
            fault   <= fault_next;
            pending <= pending_next;
            data    <= data_next;
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// tb/tb_cpu_fetch.sv - directed and randomized checks of cpu_fetch against a bench model
module tb_cpu_fetch;
    import cpu_fetch_pkg::*;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] ADD    = 32'h00A5_8533;
    localparam logic [31:0] BRANCH = 32'hFE00_0EE3;
    localparam logic [31:0] JAL    = 32'h0000_006F;
    localparam int          TMOD   = 1 << TAG_W;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fault, req, ready, stall, jump;
    logic [31:0] addr, rdata, jump_pc;
    tag_t        jump_tag;
    fetch_data_t data;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem [logic [31:0]];
    logic [63:0] pend_q [$];
    logic [31:0] exp_addr;
    int          pub_n;
    fetch_data_t exp_last;

    always #5 clk = ~clk;

    cpu_fetch #(.RESET_VECTOR(32'h0000_0000)) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .o_fault       (fault),
        .o_bus_request (req),
        .i_bus_ready   (ready),
        .o_bus_address (addr),
        .i_bus_rdata   (rdata),
        .i_stall       (stall),
        .i_jump        (jump),
        .i_jump_tag    (jump_tag),
        .i_jump_pc     (jump_pc),
        .o_data        (data)
    );

    function automatic fetch_data_t mk(input logic [31:0] pc, input logic [31:0] w, input int n);
        fetch_data_t r;
        r.pc          = pc;
        r.instruction = w;
        r.inst_rs1    = reg_idx_t'((w >> 15) & 32'd31);
        r.inst_rs2    = reg_idx_t'((w >> 20) & 32'd31);
        r.inst_rs3    = reg_idx_t'((w >> 27) & 32'd31);
        r.inst_rd     = reg_idx_t'((w >> 7) & 32'd31);
        r.tag         = tag_t'(n % TMOD);
        return r;
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = ($urandom & 32'hFFFF_FF80) | 32'h0000_0013;
        return mem[a];
    endfunction

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of bus traffic; the model is an ordered list of delivered words.
    task automatic rand_cycle(input bit rdy, input bit stl);
        logic [63:0] e;
        bit          hs;
        ready = rdy;
        stall = stl;
        rdata = word_at(addr);
        hs    = req && rdy;
        if (hs) begin
            check("hs_addr", 96'(addr), 96'(exp_addr));
            pend_q.push_back({exp_addr, word_at(exp_addr)});
            exp_addr += 32'd4;
        end
        step();
        if (!stl && pend_q.size() > 0) begin
            e = pend_q.pop_front();
            pub_n++;
            exp_last = mk(e[63:32], e[31:0], pub_n);
            check("publish", 96'(data), 96'(exp_last));
        end else begin
            check("hold", 96'(data), 96'(exp_last));
        end
        if (pend_q.size() > 0) check("req_while_held", 96'(req), 96'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; ready = 1'b0; stall = 1'b0; jump = 1'b0;
        jump_tag = '0; jump_pc = '0; rdata = '0;
        mem[32'h0] = NOP; mem[32'h4] = NOP; mem[32'h8] = NOP;
        mem[32'hC] = ADD; mem[32'h10] = BRANCH;

        #12;
        check("reset_fault", 96'(fault), 96'(0));
        check("reset_req", 96'(req), 96'(0));
        check("reset_addr", 96'(addr), 96'(32'h0));
        check("reset_data", 96'(data), 96'(0));
        #5 rst_n = 1'b1;

        step();
        check("first_req", 96'(req), 96'(1));
        check("first_addr", 96'(addr), 96'(0));
        ready = 1'b1;
        rdata = word_at(addr);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("seq_addr", 96'(addr), 96'(4 * k));
            check("seq_req", 96'(req), 96'(1));
            check("seq_tag", 96'(data.tag), 96'(k));
            check("seq_pc", 96'(data.pc), 96'(4 * (k - 1)));
            check("seq_word", 96'(data.instruction), 96'(NOP));
            rdata = word_at(addr);
        end

        step();
        check("add_rd", 96'(data.inst_rd), 96'(10));
        check("add_rs1", 96'(data.inst_rs1), 96'(11));
        check("add_rs2", 96'(data.inst_rs2), 96'(10));
        check("add_rs3", 96'(data.inst_rs3), 96'(0));
        check("br_addr", 96'(addr), 96'(32'h10));
        rdata = word_at(addr);

        step();
        check("br_req", 96'(req), 96'(0));
        check("br_data", 96'(data), 96'(mk(32'h10, BRANCH, 5)));
        jump = 1'b1; jump_tag = tag_t'(4); jump_pc = 32'h200;
        step();
        check("wrong_tag_req", 96'(req), 96'(0));
        check("wrong_tag_addr", 96'(addr), 96'(32'h10));
        jump_tag = tag_t'(5); jump_pc = 32'h100;
        step();
        jump = 1'b0;
        check("jump_req", 96'(req), 96'(1));
        check("jump_addr", 96'(addr), 96'(32'h100));

        stall = 1'b1;
        rdata = word_at(addr);
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_req", 96'(req), 96'(0));
            check("stall_data", 96'(data), 96'(mk(32'h10, BRANCH, 5)));
        end
        stall = 1'b0;
        step();
        check("release_data", 96'(data), 96'(mk(32'h100, mem[32'h100], 6)));
        check("release_req", 96'(req), 96'(1));
        check("release_addr", 96'(addr), 96'(32'h104));

        exp_addr = 32'h104;
        pub_n    = 6;
        exp_last = mk(32'h100, mem[32'h100], 6);
        for (int i = 0; i < 80; i++) begin
            rand_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
        end
        rand_cycle(1'b0, 1'b0);

        for (int g = 0; g < 40 && (pub_n % TMOD) != TMOD - 1; g++) rand_cycle(1'b1, 1'b0);
        check("tag_max", 96'(data.tag), 96'(TMOD - 1));
        rand_cycle(1'b1, 1'b0);
        check("tag_wrap", 96'(data.tag), 96'(0));

        mem[exp_addr] = JAL;
        rand_cycle(1'b1, 1'b0);
        check("jal_req", 96'(req), 96'(0));
        jump = 1'b1; jump_tag = tag_t'(pub_n % TMOD); jump_pc = 32'h102;
        step();
        jump = 1'b0;
        check("mis_fault", 96'(fault), 96'(1));
        check("mis_req", 96'(req), 96'(0));
        step();
        step();
        check("halt_fault", 96'(fault), 96'(1));
        check("halt_req", 96'(req), 96'(0));
        #2 rst_n = 1'b0;
        #1;
        check("reset_clears_fault", 96'(fault), 96'(0));

        #3 rst_n = 1'b1;
        step();
        check("rerun_req", 96'(req), 96'(1));
        check("rerun_addr", 96'(addr), 96'(0));
        check("rerun_data", 96'(data), 96'(0));
        ready = 1'b1;
        rdata = NOP;
        #3 rst_n = 1'b0;
        #1;
        check("async_req_drop", 96'(req), 96'(0));
        step();
        check("late_ready_ignored", 96'(data), 96'(0));
        check("late_req", 96'(req), 96'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
